// File: rtl/count32_auto_freq.sv
// count32_auto_freq
//   Divides the upstream tick pulse by one of four rates (DIV0..DIV3 ticks per step) and drives a
//   0..CNT_MAX counter. After every LAPS complete passes the rate advances F0->F1->F2->F3->F0.
//
// Ports
//   clki      in   system clock
//   reset     in   synchronous active-high reset, priority over everything
//   tick      in   one-cycle tick pulse (held high = one tick per cycle)
//   en        in   run enable; 0 holds all state
//   count     out  [4:0] current count
//   freq_sel  out  [1:0] active rate 0..3
//   step      out  registered pulse, high in the cycle count shows a new value
//   lap_done  out  registered pulse, high in the cycle freq_sel shows the advanced rate
//
// Optional build macro MANUAL_SEL_EN adds:
//   manual    in   1 suppresses auto-advance
//   sel_in    in   [1:0] rate forced while manual=1
module count32_auto_freq #(
    parameter int unsigned DIV0    = 1,
    parameter int unsigned DIV1    = 2,
    parameter int unsigned DIV2    = 4,
    parameter int unsigned DIV3    = 8,
    parameter int unsigned CNT_MAX = 31,
    parameter int unsigned LAPS    = 1
) (
    input  logic       clki,
    input  logic       reset,
    input  logic       tick,
    input  logic       en,
`ifdef MANUAL_SEL_EN
    input  logic       manual,
    input  logic [1:0] sel_in,
`endif
    output logic [4:0] count,
    output logic [1:0] freq_sel,
    output logic       step,
    output logic       lap_done
);

    typedef enum logic [1:0] {StF0, StF1, StF2, StF3} state_e;

    localparam logic [7:0] DivLast0 = 8'(DIV0 - 1);
    localparam logic [7:0] DivLast1 = 8'(DIV1 - 1);
    localparam logic [7:0] DivLast2 = 8'(DIV2 - 1);
    localparam logic [7:0] DivLast3 = 8'(DIV3 - 1);
    localparam logic [4:0] CntMax   = 5'(CNT_MAX);
    localparam logic [3:0] LapLast  = 4'(LAPS - 1);

    state_e     state;
    logic [7:0] div_cnt;
    logic [3:0] lap_cnt;
    logic [7:0] div_last;
    logic       sel_load;
    logic       auto_ok;

    // Terminal value of the tick divider for the active rate.
    always_comb begin
        div_last = DivLast0;
        unique case (state)
            StF0: div_last = DivLast0;
            StF1: div_last = DivLast1;
            StF2: div_last = DivLast2;
            StF3: div_last = DivLast3;
            default: div_last = DivLast0;
        endcase
    end

`ifdef MANUAL_SEL_EN
    // A forced rate change restarts the divider and the lap tally.
    assign sel_load = manual && (sel_in != state);
    assign auto_ok  = !manual;
`else
    assign sel_load = 1'b0;
    assign auto_ok  = 1'b1;
`endif

    always_ff @(posedge clki) begin
        if (reset) begin
            state    <= StF0;
            count    <= 5'd0;
            div_cnt  <= 8'd0;
            lap_cnt  <= 4'd0;
            step     <= 1'b0;
            lap_done <= 1'b0;
        end else begin
            step     <= 1'b0;
            lap_done <= 1'b0;
            if (sel_load) begin
`ifdef MANUAL_SEL_EN
                state   <= state_e'(sel_in);
`endif
                div_cnt <= 8'd0;
                lap_cnt <= 4'd0;
            end else if (tick && en) begin
                if (div_cnt == div_last) begin
                    div_cnt <= 8'd0;
                    step    <= 1'b1;
                    if (count == CntMax) begin
                        count <= 5'd0;
                        // Wrap: rate change and lap_done land on the same edge as the count wrap.
                        if (auto_ok) begin
                            if (lap_cnt == LapLast) begin
                                lap_cnt  <= 4'd0;
                                state    <= state_e'(state + 2'd1);
                                lap_done <= 1'b1;
                            end else begin
                                lap_cnt <= lap_cnt + 4'd1;
                            end
                        end
                    end else begin
                        count <= count + 5'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

    assign freq_sel = state;

endmodule

// File: tb/tb_count32_auto_freq.sv
module tb_count32_auto_freq;

    logic       clki = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       en = 1'b0;
    logic [4:0] count;
    logic [1:0] freq_sel;
    logic       step;
    logic       lap_done;

    count32_auto_freq dut (
        .clki     (clki),
        .reset    (reset),
        .tick     (tick),
        .en       (en),
`ifdef MANUAL_SEL_EN
        .manual   (1'b0),
        .sel_in   (2'b00),
`endif
        .count    (count),
        .freq_sel (freq_sel),
        .step     (step),
        .lap_done (lap_done)
    );

    always #5 clki = ~clki;

    typedef struct {
        int count;
        int fs;
        bit step;
        bit lap;
    } exp_t;

    typedef struct {
        int ncyc;
        bit rst;
        bit tk;
        bit en;
        int exp_count;
        int exp_fs;
        int exp_steps;
        int exp_laps;
    } vec_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   seg_steps = 0;
    int   seg_laps = 0;

    // Reference model state
    int m_count = 0, m_fs = 0, m_div = 0, m_lap = 0;

    function automatic int ticks_per_step(input int fs);
        case (fs)
            0: return 1;
            1: return 2;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock: drive inputs, push model prediction, sample after the edge and compare.
    task automatic cyc(input bit r, input bit t, input bit e);
        exp_t x;
        reset = r;
        tick  = t;
        en    = e;
        x.step = 1'b0;
        x.lap  = 1'b0;
        if (r) begin
            m_count = 0; m_fs = 0; m_div = 0; m_lap = 0;
        end else if (t && e) begin
            m_div++;
            if (m_div == ticks_per_step(m_fs)) begin
                m_div  = 0;
                x.step = 1'b1;
                m_count++;
                if (m_count == 32) begin
                    m_count = 0;
                    m_fs    = (m_fs + 1) % 4;
                    x.lap   = 1'b1;
                end
            end
        end
        x.count = m_count;
        x.fs    = m_fs;
        sb.push_back(x);
        @(posedge clki);
        #1;
        x = sb.pop_front();
        chk("count", int'(count), x.count);
        chk("freq_sel", int'(freq_sel), x.fs);
        chk("step", int'(step), int'(x.step));
        chk("lap_done", int'(lap_done), int'(x.lap));
        if (step) seg_steps++;
        if (lap_done) seg_laps++;
    endtask

    vec_t vecs[8];
    int   rot_steps;
    int   rot_laps;
    int   wait_n;
    bit   seen;
    int   hold_count;
    int   hold_fs;

    initial begin
        // Segments: cycles, reset, tick, en, then count/freq_sel at the end and pulses seen.
        vecs[0] = '{2,   1, 1, 1, 0,  0, 0,  0};
        vecs[1] = '{31,  0, 1, 1, 31, 0, 31, 0};
        vecs[2] = '{1,   0, 1, 1, 0,  1, 1,  1};
        vecs[3] = '{64,  0, 1, 1, 0,  2, 32, 1};
        vecs[4] = '{10,  0, 0, 1, 0,  2, 0,  0};
        vecs[5] = '{128, 0, 1, 1, 0,  3, 32, 1};
        vecs[6] = '{256, 0, 1, 1, 0,  0, 32, 1};
        vecs[7] = '{5,   0, 1, 0, 0,  0, 0,  0};

        @(posedge clki);
        #1;
        rot_steps = 0;
        rot_laps  = 0;
        for (int v = 0; v < 8; v++) begin
            seg_steps = 0;
            seg_laps  = 0;
            for (int c = 0; c < vecs[v].ncyc; c++) cyc(vecs[v].rst, vecs[v].tk, vecs[v].en);
            chk($sformatf("vec%0d_count", v), int'(count), vecs[v].exp_count);
            chk($sformatf("vec%0d_freq_sel", v), int'(freq_sel), vecs[v].exp_fs);
            chk($sformatf("vec%0d_steps", v), seg_steps, vecs[v].exp_steps);
            chk($sformatf("vec%0d_laps", v), seg_laps, vecs[v].exp_laps);
            if (v >= 1 && v <= 6) begin
                rot_steps += seg_steps;
                rot_laps  += seg_laps;
            end
        end
        chk("rotation_steps", rot_steps, 128);
        chk("rotation_laps", rot_laps, 4);

        // Sparse random ticks and enable, checked cycle by cycle against the model.
        for (int c = 0; c < 400; c++)
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

        // F3 with div_cnt=5: en low with tick high must freeze, then 3 ticks to the next step.
        cyc(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 224; c++) cyc(1'b0, 1'b1, 1'b1);
        chk("f3_reached", int'(freq_sel), 3);
        for (int c = 0; c < 5; c++) cyc(1'b0, 1'b1, 1'b1);
        hold_count = int'(count);
        hold_fs    = int'(freq_sel);
        seg_steps  = 0;
        for (int c = 0; c < 10; c++) cyc(1'b0, 1'b1, 1'b0);
        chk("en_hold_count", int'(count), hold_count);
        chk("en_hold_freq_sel", int'(freq_sel), hold_fs);
        chk("en_hold_steps", seg_steps, 0);
        wait_n = 0;
        seen   = 1'b0;
        while (!seen && wait_n < 20) begin
            cyc(1'b0, 1'b1, 1'b1);
            wait_n++;
            if (step) seen = 1'b1;
        end
        chk("en_resume_seen", int'(seen), 1);
        chk("en_resume_ticks", wait_n, 3);

        // Count 17 in F2, then reset together with tick.
        cyc(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 96 + 68; c++) cyc(1'b0, 1'b1, 1'b1);
        chk("pre_reset_count", int'(count), 17);
        chk("pre_reset_freq_sel", int'(freq_sel), 2);
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_count", int'(count), 0);
        chk("rst_freq_sel", int'(freq_sel), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_lap_done", int'(lap_done), 0);
        // Divider must restart from zero: the very next tick steps at DIV0=1.
        cyc(1'b0, 1'b1, 1'b1);
        chk("post_rst_step", int'(step), 1);
        chk("post_rst_count", int'(count), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
